// File: rtl/m_fmap_feeder_if.sv
// Pixel-stream bundle between an upstream conv layer, the feature-map feeder and the next conv layer.
// master: the testbench/system side that drives map_in/save/down_ready and observes the replay.
// slave:  the feeder itself (m_fmap_feeder).
interface m_fmap_feeder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] map_in;      // upstream pixel, valid with save
  logic              save;        // upstream write strobe
  logic              fill_ready;  // feeder accepting pixels
  logic [DATA_W-1:0] map_out;     // replayed pixel to next layer
  logic              start;       // next-layer enable
  logic              down_ready;  // next layer still busy when 1
  logic              done;        // one-cycle completion pulse
  logic              overflow;    // sticky: save seen outside FILL

  modport master (
    output map_in, save, down_ready,
    input  fill_ready, map_out, start, done, overflow
  );

  modport slave (
    input  map_in, save, down_ready,
    output fill_ready, map_out, start, done, overflow
  );
endinterface

// File: rtl/m_fmap_feeder.sv
// Purpose: buffers one feature map from the upstream layer, replays it raster-order with a zero tail.
// Latency: first replayed pixel 1 cycle after the read is issued; start is aligned with pixel 0.
// Backpressure: replay waits for down_ready=1 at entry; completion when down_ready falls after the tail.
// Ports: clk_in, rst_n (async, active-low); fm (slave modport): map_in/save in, fill_ready,
//   map_out/start out, down_ready in, done/overflow out.
module m_fmap_feeder #(
  parameter int DATA_W   = 16,
  parameter int NUM_PIX  = 7744,
  parameter int ADDR_W   = 13,
  parameter int TAIL_CYC = 1024
) (
  input  logic             clk_in,
  input  logic             rst_n,
  m_fmap_feeder_if.slave   fm
);

  localparam int TAIL_W = $clog2(TAIL_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  // TAIL lasts TAIL_CYC+1 state cycles: its first cycle still displays the
  // last pixel (read latency), the remaining TAIL_CYC cycles display zeros.
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYC);

  typedef enum logic [1:0] {
    S_FILL,
    S_STREAM,
    S_TAIL,
    S_WAIT_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic [TAIL_W-1:0] tail_cnt;
  logic              wr_en, rd_en;
  logic              start_nxt, done_nxt;
  logic              start_q, done_q, rd_vld, overflow_q;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Reads only start once the downstream is ready; after the first address
  // is issued the replay runs gapless regardless of down_ready.
  assign wr_en = (state == S_FILL) && fm.save;
  assign rd_en = (state == S_STREAM) && ((rd_cnt != '0) || fm.down_ready);

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_FILL: begin
        if (wr_en && (wr_cnt == LAST_ADDR)) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        start_nxt = rd_en;
        if (rd_en && (rd_cnt == LAST_ADDR)) state_nxt = S_TAIL;
      end
      S_TAIL: begin
        start_nxt = 1'b1;
        if (tail_cnt == TAIL_LAST) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (fm.down_ready) begin
          start_nxt = 1'b1;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      tail_cnt   <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_vld     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start_nxt;
      done_q  <= done_nxt;
      rd_vld  <= rd_en;
      if (fm.save && (state != S_FILL)) overflow_q <= 1'b1;

      if (wr_en) wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;

      if (state == S_TAIL) tail_cnt <= (tail_cnt == TAIL_LAST) ? '0 : tail_cnt + 1'b1;
      else                 tail_cnt <= '0;

      if (done_nxt) begin
        wr_cnt   <= '0;
        rd_cnt   <= '0;
        tail_cnt <= '0;
      end
    end
  end

  // Plain RAM: no reset so it maps onto block memory; rd_vld gates the output.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_cnt] <= fm.map_in;
    if (rd_en) rd_dat <= mem[rd_cnt];
  end

  assign fm.map_out    = rd_vld ? rd_dat : '0;
  assign fm.start      = start_q;
  assign fm.done       = done_q;
  assign fm.overflow   = overflow_q;
  assign fm.fill_ready = (state == S_FILL);

endmodule

// File: tb/tb_m_fmap_feeder.sv
module tb_m_fmap_feeder;
  localparam int NP = 16;
  localparam int TC = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  m_fmap_feeder_if #(.DATA_W(16)) fm_if ();

  m_fmap_feeder #(
    .DATA_W(16), .NUM_PIX(NP), .ADDR_W(4), .TAIL_CYC(TC)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .fm    (fm_if)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in terms of map occupancy and replay position k:
  // k indexes output cycles since start rose; k<NP shows pixel k, then zeros;
  // from k>=NP+TC down_ready is sampled and a 0 ends the replay.
  logic [15:0] m_mem [NP];
  int  m_wr = 0, m_k = 0;
  bit  m_full = 0, m_rep = 0, m_done = 0, m_ovf = 0;
  bit  cmp_en = 0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; m_k = 0; m_full = 0; m_rep = 0; m_done = 0; m_ovf = 0;
    end else begin
      bit done_n;
      done_n = 0;
      if (fm_if.save && m_full) m_ovf = 1;
      if (m_rep) begin
        if (m_k >= NP + TC && !fm_if.down_ready) begin
          m_rep = 0; m_full = 0; m_wr = 0; done_n = 1;
        end else begin
          m_k++;
        end
      end else if (m_full) begin
        if (fm_if.down_ready) begin
          m_rep = 1; m_k = 0;
        end
      end else if (fm_if.save) begin
        m_mem[m_wr] = fm_if.map_in;
        m_wr++;
        if (m_wr == NP) m_full = 1;
      end
      m_done = done_n;
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en) begin
      logic [15:0] exp_map;
      exp_map = (m_rep && m_k < NP) ? m_mem[m_k] : 16'h0000;
      chk("map_out",    fm_if.map_out,    exp_map);
      chk("start",      fm_if.start,      m_rep);
      chk("fill_ready", fm_if.fill_ready, !m_full);
      chk("done",       fm_if.done,       m_done);
      chk("overflow",   fm_if.overflow,   m_ovf);
      chk("done_with_start", fm_if.done & fm_if.start, 0);
    end
  end

  logic [15:0] pix [NP];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Contiguous fill of pix[], ending just after the last write edge.
  task automatic fill_contig(input string name);
    for (int i = 0; i < NP; i++) begin
      fm_if.save   = 1'b1;
      fm_if.map_in = pix[i];
      if (i == NP - 1) chk({name, "_ready_before_last"}, fm_if.fill_ready, 1);
      tick();
    end
    fm_if.save = 1'b0;
    chk({name, "_ready_fall"}, fm_if.fill_ready, 0);
  endtask

  task automatic wait_start(input string name);
    int i;
    i = 0;
    @(negedge clk_in);
    while (!fm_if.start && i < 40) begin
      @(negedge clk_in);
      i++;
    end
    chk({name, "_start_seen"}, fm_if.start, 1);
  endtask

  // Called at the negedge of the first start cycle.
  task automatic check_replay(input string name);
    for (int j = 0; j < NP; j++) begin
      if (j > 0) @(negedge clk_in);
      chk({name, "_pix"}, fm_if.map_out, pix[j]);
      chk({name, "_pix_start"}, fm_if.start, 1);
    end
    for (int j = 0; j < TC; j++) begin
      @(negedge clk_in);
      chk({name, "_tail"}, fm_if.map_out, 0);
      chk({name, "_tail_start"}, fm_if.start, 1);
    end
  endtask

  // Keeps down_ready high for n wait cycles, then low for one; returns at
  // the start of the FILL re-entry cycle with down_ready back high.
  task automatic end_wait(input string name, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk_in);
      chk({name, "_wait_start"}, fm_if.start, 1);
      chk({name, "_wait_done"},  fm_if.done,  0);
    end
    @(posedge clk_in);
    #1 fm_if.down_ready = 1'b0;
    @(negedge clk_in);
    chk({name, "_drop_start"}, fm_if.start, 1);
    @(posedge clk_in);
    #1 fm_if.down_ready = 1'b1;
  endtask

  task automatic finish_check(input string name);
    @(negedge clk_in);
    chk({name, "_done_pulse"}, fm_if.done, 1);
    chk({name, "_done_start"}, fm_if.start, 0);
    chk({name, "_done_ready"}, fm_if.fill_ready, 1);
  endtask

  initial begin
    fm_if.map_in     = '0;
    fm_if.save       = 1'b0;
    fm_if.down_ready = 1'b1;
    #2;
    chk("rst_map_out",    fm_if.map_out, 0);
    chk("rst_start",      fm_if.start, 0);
    chk("rst_fill_ready", fm_if.fill_ready, 1);
    chk("rst_done",       fm_if.done, 0);
    chk("rst_overflow",   fm_if.overflow, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    cmp_en = 1;

    // Contiguous fill 0001..0010, replay, 10 wait cycles, then done.
    for (int i = 0; i < NP; i++) pix[i] = 16'(i + 1);
    fill_contig("c2");
    wait_start("c2");
    chk("c2_first_literal", fm_if.map_out, 16'h0001);
    check_replay("c2");
    end_wait("c4", 10);
    // Save on the FILL re-entry cycle becomes pixel 0 of the next map.
    for (int i = 0; i < NP; i++) pix[i] = 16'hFFFF - 16'(i);
    fm_if.save   = 1'b1;
    fm_if.map_in = pix[0];
    finish_check("c4");
    @(posedge clk_in);
    #1 fm_if.save = 1'b0;
    @(negedge clk_in);
    chk("c4_done_single", fm_if.done, 0);

    // Gapped saves of -1..-16; replay must be gapless.
    for (int i = 1; i < NP; i++) begin
      tick();
      fm_if.save = 1'b0;
      tick();
      tick();
      fm_if.save   = 1'b1;
      fm_if.map_in = pix[i];
    end
    tick();
    fm_if.save = 1'b0;
    chk("c3_ready_fall", fm_if.fill_ready, 0);
    chk("c3_no_ovf", fm_if.overflow, 0);
    wait_start("c3");
    chk("c3_first_literal", fm_if.map_out, 16'hFFFF);
    check_replay("c3");
    chk("c3_last_zero", fm_if.map_out, 16'h0000);
    end_wait("c3", 0);
    fm_if.down_ready = 1'b0;
    finish_check("c3");

    // Full map with downstream not ready: stall, overflow from a save, then replay.
    for (int i = 0; i < NP; i++) pix[i] = 16'(i + 1);
    tick();
    fill_contig("c5");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_in);
      chk("c5_stall_start", fm_if.start, 0);
      chk("c5_stall_map",   fm_if.map_out, 0);
    end
    @(posedge clk_in);
    #1 fm_if.save = 1'b1;
    fm_if.map_in = 16'h7FFF;
    tick();
    fm_if.save = 1'b0;
    chk("c6_overflow_set", fm_if.overflow, 1);
    chk("c5_still_stalled", fm_if.start, 0);
    fm_if.down_ready = 1'b1;
    wait_start("c5");
    chk("c5_first_literal", fm_if.map_out, 16'h0001);
    check_replay("c5");
    end_wait("c5", 3);
    finish_check("c5");
    chk("c6_overflow_sticky", fm_if.overflow, 1);

    // Save during an active replay: dropped, current replay unaffected.
    for (int i = 0; i < NP; i++) pix[i] = 16'h0101 * 16'(i + 1);
    tick();
    fill_contig("c6");
    wait_start("c6");
    fork
      check_replay("c6");
      begin
        repeat (4) @(posedge clk_in);
        #1 fm_if.save = 1'b1;
        fm_if.map_in = 16'h7FFF;
        tick();
        fm_if.save = 1'b0;
      end
    join
    end_wait("c6", 1);
    finish_check("c6");

    // Asynchronous reset in the middle of a replay.
    for (int i = 0; i < NP; i++) pix[i] = 16'(i + 1);
    tick();
    fill_contig("c1");
    wait_start("c1");
    repeat (3) @(negedge clk_in);
    chk("c1_mid_pix", fm_if.map_out, 16'h0004);
    #2 rst_n = 1'b0;
    #1;
    chk("c1_async_map_out",    fm_if.map_out, 0);
    chk("c1_async_start",      fm_if.start, 0);
    chk("c1_async_fill_ready", fm_if.fill_ready, 1);
    chk("c1_async_overflow",   fm_if.overflow, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("c1_post_start", fm_if.start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
